// File: rtl/lane_packer16.sv
// Packs per-lane predicted bits from markov16 into words and queues them in a small
// valid/ready FIFO; a flush command drains every partially filled lane as a short word.
module lane_packer16 #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              bit_in,
    input  logic [3:0]        lane,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [3:0]        out_lane,
    output logic [LEN_W-1:0]  out_len,
    output logic              flush_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = WORD_W + 4 + LEN_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [WORD_W-1:0] shreg [16];
    logic [LEN_W-1:0]  cnt   [16];

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic [0:0]        state;
    logic [3:0]        scan_idx;
    logic              flush_done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;
    logic              push;
    logic [ENT_W-1:0]  push_data;

    logic [LEN_W-1:0]  cur_cnt;
    logic [WORD_W-1:0] ins_word;
    logic              word_done;
    logic [LEN_W-1:0]  scan_cnt;
    logic              scan_busy;
    logic              scan_adv;

    logic [WORD_W-1:0] head_word;
    logic [3:0]        head_lane;
    logic [LEN_W-1:0]  head_len;

    // Full is the registered occupancy only, so a pop never frees a slot in the same cycle.
    assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
    assign fifo_empty = (occ == '0);
    assign in_ready   = (state == IDLE) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign flush_done = flush_done_q;

    assign cur_cnt   = cnt[lane];
    assign word_done = (cur_cnt == LEN_W'(WORD_W - 1));
    assign scan_cnt  = cnt[scan_idx];
    assign scan_busy = (scan_cnt != '0);
    assign scan_adv  = (state == FLUSH) && (!scan_busy || !fifo_full);

    always_comb begin
        ins_word = shreg[lane];
        for (int b = 0; b < WORD_W; b++) begin
            if (cur_cnt == LEN_W'(b)) begin
                ins_word[b] = bit_in;
            end
        end
    end

    // Input pushes only happen in IDLE and scan pushes only in FLUSH, so they never collide.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (accept && word_done) begin
            push      = 1'b1;
            push_data = {ins_word, lane, LEN_W'(WORD_W)};
        end else if ((state == FLUSH) && scan_busy && !fifo_full) begin
            push      = 1'b1;
            push_data = {shreg[scan_idx], scan_idx, scan_cnt};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                shreg[i] <= '0;
                cnt[i]   <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            state        <= IDLE;
            scan_idx     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;

            if (accept) begin
                if (word_done) begin
                    shreg[lane] <= '0;
                    cnt[lane]   <= '0;
                end else begin
                    shreg[lane] <= ins_word;
                    cnt[lane]   <= cur_cnt + LEN_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (flush) begin
                        state    <= FLUSH;
                        scan_idx <= '0;
                    end
                end
                FLUSH: begin
                    if (scan_adv) begin
                        if (scan_busy) begin
                            shreg[scan_idx] <= '0;
                            cnt[scan_idx]   <= '0;
                        end
                        if (scan_idx == 4'd15) begin
                            state        <= IDLE;
                            flush_done_q <= 1'b1;
                        end else begin
                            scan_idx <= scan_idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Outputs read as zero whenever nothing is queued, hiding stale FIFO contents.
    assign {head_word, head_lane, head_len} = fifo_mem[rd_ptr];
    assign out_word = fifo_empty ? '0 : head_word;
    assign out_lane = fifo_empty ? '0 : head_lane;
    assign out_len  = fifo_empty ? '0 : head_len;

endmodule

// File: doc/lane_packer16.md
# lane_packer16

Downstream consumer of the 16-lane Markov predictor (`markov16`). Each cycle it takes one predicted bit plus its 4-bit lane index and accumulates bits per lane into words. Each full word is pushed into a small output FIFO with a valid/ready interface. A flush command drains every partially filled lane as short words, so the end of a stream can be emptied cleanly.

## Interface
Parameters:
- `WORD_W`, 8: bits per packed word (2..16).
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `LEN_W`, `$clog2(WORD_W+1)` (4 for default): width of `out_len`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `bit_in`/`lane` valid this cycle.
- `bit_in`  in  1  data bit (predictor `bit_out`).
- `lane`  in  4  destination lane 0..15.
- `in_ready`  out  1  block accepts an input this cycle.
- `flush`  in  1  request to drain partial lanes (pulse).
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes the head this cycle.
- `out_word`  out  `WORD_W`  packed word, LSB = first bit received.
- `out_lane`  out  4  lane the word belongs to.
- `out_len`  out  `LEN_W`  number of valid bits in `out_word` (1..`WORD_W`).
- `flush_done`  out  1  one-cycle pulse when a flush completes.

## Operation
Per-lane state (×16):
- `WORD_W`-bit shift register.
- Fill count 0..`WORD_W`-1.

Input acceptance:
- An input is accepted when `in_valid & in_ready`.
- `in_ready = (state==IDLE) & !fifo_full`.
- `fifo_full` is the registered occupancy only. There is no same-cycle bypass from a pop.

Accepted bit handling:
- The bit is written at position `count[lane]` of `lane`'s register, and `count` increments.
- If the count was `WORD_W-1`, the completed word (the new bit in the MSB) is pushed with `out_len=WORD_W`, and that lane's count and register clear to 0.

Output side:
- `out_valid = !fifo_empty`. The head is popped on `out_valid & out_ready`.
- When the FIFO is empty, `out_word`, `out_lane` and `out_len` are driven to 0.
- Push and pop in the same cycle are both performed, and occupancy is unchanged.

FSM states: IDLE, FLUSH.
- IDLE → FLUSH: on `flush=1`. The scan index is set to 0. In that same cycle `in_ready` still applies, so an input accepted in the flush cycle is included in the flush.
- FLUSH, one lane per cycle at the scan index:
  - If count=0: skip and advance the index.
  - If count>0 and the FIFO is not full: push {lane register with unused upper bits 0, index, count}, clear the lane, and advance.
  - If count>0 and the FIFO is full: stall on this index.
- FLUSH → IDLE: after index 15 is handled. `flush_done` is 1 for exactly the cycle following that transition edge.
- `flush` is ignored while in FLUSH. `in_ready` is 0 throughout FLUSH.

Reset (at a posedge with `reset=1`, from any state, including mid-flush or with a full FIFO):
- All counts and registers are 0, the FIFO is empty, and the state is IDLE.
- Outputs: `in_ready=1`, `out_valid=0`, `out_word=0`, `out_lane=0`, `out_len=0`, `flush_done=0`.
- Partial words and queued words are discarded.

## Timing
- Completing bit accepted at edge N → `out_valid=1` with that word after edge N (1-cycle latency).
- Flush issued at edge N: the lane-0 decision is made in the cycle after N. A full scan with no stalls takes 16 cycles. `flush_done` is high in the 17th cycle after N.
- FIFO full after edge N → `in_ready=0` for the cycle after N, even if `out_ready=1` in that cycle. `in_ready` returns the cycle after a pop.
- Lane counts are independent. Interleaved lanes never corrupt each other's bit order.

## Test plan
- **Single-lane word:** lane 3, bits 1,0,1,1,0,0,1,0 on consecutive cycles, `out_ready=1` → exactly one output with `out_word=0x4D`, `out_lane=3`, `out_len=8`, one cycle after the 8th bit.
- **Interleaved lanes:** alternate lane 0 (all 1s) and lane 15 (all 0s), 16 inputs → words `0xFF`/lane 0 then `0x00`/lane 15, in that order.
- **Backpressure:** `out_ready=0`, 5 full words on lane 1 → `in_ready` drops after the 4th word's last bit is accepted, and the 5th word's bits are held off. Raising `out_ready` pops 4 words in order, `in_ready` re-asserts, and the 5th word is accepted.
- **Flush:** lane 2 holds 1,1,0 and lane 9 holds 1, then `flush` is pulsed → `0x03`/lane 2/len 3, then `0x01`/lane 9/len 1. `flush_done` pulses 17 cycles after the flush edge, and all counts are 0 afterward.
- **Flush with full FIFO:** 4 queued words, `out_ready=0`, partial data on lane 5, then flush → the scan stalls at index 5 until a pop, then emits the partial word. `flush_done` is delayed by exactly the stall cycles.
- **Reset mid-flush:** reset asserted at scan index 7 → the next cycle shows all reset values. A subsequent 8-bit word on lane 7 packs from bit 0.
